// File: rtl/rom_fetch_ctrl.sv
// Read-side fetch controller for the 7-step processor program ROM.
// Walks the ROM's latch-then-enable protocol and hands each byte to the core.
module rom_fetch_ctrl #(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 8,
  parameter int AUTO_RUN = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              fetch_req,
  input  logic              jump_en,
  input  logic [ADDR_W-1:0] jump_addr,
  input  logic [ADDR_W-1:0] noi,
  input  logic [DATA_W-1:0] rom_data,
  output logic [ADDR_W-1:0] rom_addr,
  output logic              rom_set_addr,
  output logic              rom_en_data,
  output logic [DATA_W-1:0] byte_out,
  output logic              byte_valid,
  output logic [ADDR_W-1:0] pc,
  output logic              busy,
  output logic              done
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_WAIT     = 3'd1;
  localparam logic [2:0] S_SET_ADDR = 3'd2;
  localparam logic [2:0] S_EN_DATA  = 3'd3;
  localparam logic [2:0] S_VALID    = 3'd4;
  localparam logic [2:0] S_DONE     = 3'd5;

  localparam logic AUTO = (AUTO_RUN != 0);

  logic [2:0]        state_reg;
  logic [ADDR_W-1:0] pc_reg;
  logic [ADDR_W-1:0] noi_q_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [DATA_W-1:0] byte_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= S_IDLE;
      pc_reg    <= '0;
      noi_q_reg <= '0;
      addr_reg  <= '0;
      byte_reg  <= '0;
    end else begin
      case (state_reg)
        S_IDLE, S_DONE: begin
          if (start) begin
            pc_reg    <= '0;
            noi_q_reg <= noi;
            // An empty program skips WAIT only on the first start out of IDLE.
            state_reg <= (state_reg == S_IDLE && noi == '0) ? S_DONE : S_WAIT;
          end
        end
        S_WAIT: begin
          // End-of-program check has priority, so a jump past the end never touches the ROM.
          if (pc_reg >= noi_q_reg) begin
            state_reg <= S_DONE;
          end else if (jump_en) begin
            pc_reg <= jump_addr;
          end else if (fetch_req || AUTO) begin
            addr_reg  <= pc_reg;
            state_reg <= S_SET_ADDR;
          end
        end
        S_SET_ADDR: state_reg <= S_EN_DATA;
        S_EN_DATA: begin
          byte_reg  <= rom_data;
          pc_reg    <= pc_reg + ADDR_W'(1);
          state_reg <= S_VALID;
        end
        S_VALID: state_reg <= S_WAIT;
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  // Strobes decode directly from state so they are exactly one cycle and mutually exclusive.
  assign rom_set_addr = (state_reg == S_SET_ADDR);
  assign rom_en_data  = (state_reg == S_EN_DATA);
  assign byte_valid   = (state_reg == S_VALID);
  assign done         = (state_reg == S_DONE);
  assign busy         = (state_reg != S_IDLE) && (state_reg != S_DONE);
  assign rom_addr     = addr_reg;
  assign byte_out     = byte_reg;
  assign pc           = pc_reg;

endmodule

// File: tb/tb_rom_fetch_ctrl.sv
// Directed + randomized bench for rom_fetch_ctrl: one manual-fetch instance and one auto-run
// instance, each talking to a behavioural latch-then-enable ROM.
module tb_rom_fetch_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  always @(posedge clk) cyc++;

  logic [7:0] mem [256];

  // Manual instance (AUTO_RUN = 0)
  logic       a_rst, a_start, a_req, a_jen;
  logic [7:0] a_jaddr, a_noi, a_rom_data, a_addr, a_byte, a_pc, a_lat;
  logic       a_set, a_en, a_valid, a_busy, a_done;

  rom_fetch_ctrl #(.ADDR_W(8), .DATA_W(8), .AUTO_RUN(0)) dut_a (
    .clk(clk), .reset(a_rst), .start(a_start), .fetch_req(a_req), .jump_en(a_jen),
    .jump_addr(a_jaddr), .noi(a_noi), .rom_data(a_rom_data), .rom_addr(a_addr),
    .rom_set_addr(a_set), .rom_en_data(a_en), .byte_out(a_byte), .byte_valid(a_valid),
    .pc(a_pc), .busy(a_busy), .done(a_done)
  );

  always @(posedge clk) if (a_set) a_lat <= a_addr;
  assign a_rom_data = a_en ? mem[a_lat] : 8'hEE;

  // Auto-run instance (AUTO_RUN = 1)
  logic       b_rst, b_start, b_req, b_jen;
  logic [7:0] b_jaddr, b_noi, b_rom_data, b_addr, b_byte, b_pc, b_lat;
  logic       b_set, b_en, b_valid, b_busy, b_done;

  rom_fetch_ctrl #(.ADDR_W(8), .DATA_W(8), .AUTO_RUN(1)) dut_b (
    .clk(clk), .reset(b_rst), .start(b_start), .fetch_req(b_req), .jump_en(b_jen),
    .jump_addr(b_jaddr), .noi(b_noi), .rom_data(b_rom_data), .rom_addr(b_addr),
    .rom_set_addr(b_set), .rom_en_data(b_en), .byte_out(b_byte), .byte_valid(b_valid),
    .pc(b_pc), .busy(b_busy), .done(b_done)
  );

  always @(posedge clk) if (b_set) b_lat <= b_addr;
  assign b_rom_data = b_en ? mem[b_lat] : 8'hEE;

  // Strobe monitors, sampled mid-cycle
  int   a_set_cnt = 0, a_valid_cnt = 0, a_bad = 0;
  int   b_set_cnt = 0, b_bad = 0;
  logic a_set_p = 0, a_en_p = 0, b_set_p = 0, b_en_p = 0;
  logic [7:0] b_bytes [$];
  int         b_times [$];

  always @(negedge clk) begin
    if (a_set) a_set_cnt++;
    if (a_valid) a_valid_cnt++;
    if ((a_set && a_en) || (a_set && a_set_p) || (a_en && a_en_p)) a_bad++;
    a_set_p = a_set;
    a_en_p  = a_en;
    if (b_set) b_set_cnt++;
    if ((b_set && b_en) || (b_set && b_set_p) || (b_en && b_en_p)) b_bad++;
    b_set_p = b_set;
    b_en_p  = b_en;
    if (b_valid) begin
      b_bytes.push_back(b_byte);
      b_times.push_back(cyc);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_a_reset(input string tag);
    chk({tag, ".rom_addr"}, 32'(a_addr), 32'd0);
    chk({tag, ".set"},      32'(a_set), 32'd0);
    chk({tag, ".en"},       32'(a_en), 32'd0);
    chk({tag, ".byte"},     32'(a_byte), 32'd0);
    chk({tag, ".valid"},    32'(a_valid), 32'd0);
    chk({tag, ".pc"},       32'(a_pc), 32'd0);
    chk({tag, ".busy"},     32'(a_busy), 32'd0);
    chk({tag, ".done"},     32'(a_done), 32'd0);
  endtask

  // Reference program counter of the manual instance
  logic [7:0] m_pc = 8'd0;

  // One requested fetch: SET_ADDR, EN_DATA, then byte_valid three edges after the request.
  task automatic fetch_a(input string tag);
    logic [7:0] e;
    e = mem[m_pc];
    a_req = 1'b1;
    step();
    a_req = 1'b0;
    chk({tag, ".c1.set"},  32'(a_set), 32'd1);
    chk({tag, ".c1.en"},   32'(a_en), 32'd0);
    chk({tag, ".c1.addr"}, 32'(a_addr), 32'(m_pc));
    step();
    chk({tag, ".c2.set"},  32'(a_set), 32'd0);
    chk({tag, ".c2.en"},   32'(a_en), 32'd1);
    chk({tag, ".c2.addr"}, 32'(a_addr), 32'(m_pc));
    step();
    chk({tag, ".c3.valid"}, 32'(a_valid), 32'd1);
    chk({tag, ".c3.byte"},  32'(a_byte), 32'(e));
    chk({tag, ".c3.pc"},    32'(a_pc), 32'(8'(m_pc + 8'd1)));
    step();
    chk({tag, ".c4.valid"}, 32'(a_valid), 32'd0);
    chk({tag, ".c4.hold"},  32'(a_byte), 32'(e));
    m_pc = m_pc + 8'd1;
  endtask

  task automatic jump_a(input string tag, input logic [7:0] target, input logic with_req);
    a_jen   = 1'b1;
    a_jaddr = target;
    a_req   = with_req;
    step();
    a_jen = 1'b0;
    a_req = 1'b0;
    chk({tag, ".noset"}, 32'(a_set), 32'd0);
    chk({tag, ".pc"},    32'(a_pc), 32'(target));
    m_pc = target;
  endtask

  initial begin
    int s0, v0, n;
    logic [7:0] t;
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom_range(0, 255));
    mem[0]  = 8'h20;
    mem[1]  = 8'h00;
    mem[2]  = 8'h21;
    mem[12] = 8'h8B;
    mem[19] = 8'h00;

    a_rst = 1; a_start = 0; a_req = 0; a_jen = 0; a_jaddr = 0; a_noi = 0;
    b_rst = 1; b_start = 0; b_req = 0; b_jen = 0; b_jaddr = 0; b_noi = 0;
    repeat (2) step();
    chk_a_reset("reset");
    a_rst = 0;
    b_rst = 0;

    // Basic fetch
    a_noi = 8'd20;
    a_start = 1;
    step();
    a_start = 0;
    chk("start.busy", 32'(a_busy), 32'd1);
    chk("start.pc",   32'(a_pc), 32'd0);
    m_pc = 0;
    fetch_a("fetch0");
    chk("fetch0.lit", 32'(a_byte), 32'h20);
    fetch_a("fetch1");
    chk("fetch1.lit", 32'(a_byte), 32'h00);
    chk("basic.pc",   32'(a_pc), 32'd2);

    // Jump with a simultaneous request
    fetch_a("fetch2");
    fetch_a("fetch3");
    s0 = a_set_cnt;
    jump_a("jump12", 8'd12, 1'b1);
    step();
    chk("jump12.idle_wait", 32'(a_set_cnt), 32'(s0));
    chk("jump12.pc_hold",   32'(a_pc), 32'd12);
    fetch_a("fetch12");
    chk("fetch12.lit", 32'(a_byte), 32'h8B);

    // Randomized in-range jumps and fetches
    for (int r = 0; r < 8; r++) begin
      t = 8'($urandom_range(0, 15));
      jump_a("rjump", t, 1'($urandom_range(0, 1)));
      n = $urandom_range(1, 3);
      for (int k = 0; k < n; k++) fetch_a("rfetch");
    end

    // Start while busy has no effect
    a_start = 1;
    step();
    a_start = 0;
    chk("busy_start.pc",   32'(a_pc), 32'(m_pc));
    chk("busy_start.busy", 32'(a_busy), 32'd1);

    // Out-of-range jump
    jump_a("jump25", 8'd25, 1'b0);
    s0 = a_set_cnt;
    step();
    step();
    chk("jump25.done",  32'(a_done), 32'd1);
    chk("jump25.busy",  32'(a_busy), 32'd0);
    chk("jump25.pc",    32'(a_pc), 32'd25);
    chk("jump25.noset", 32'(a_set_cnt), 32'(s0));

    // Restart from DONE with a 3-byte program
    a_noi = 8'd3;
    a_start = 1;
    step();
    a_start = 0;
    chk("restart.pc",   32'(a_pc), 32'd0);
    chk("restart.busy", 32'(a_busy), 32'd1);
    m_pc = 0;
    fetch_a("r0");
    chk("r0.lit", 32'(a_byte), 32'h20);
    fetch_a("r1");
    chk("r1.lit", 32'(a_byte), 32'h00);
    fetch_a("r2");
    chk("r2.lit", 32'(a_byte), 32'h21);
    a_req = 1;
    step();
    a_req = 0;
    chk("r.done",  32'(a_done), 32'd1);
    chk("r.noset", 32'(a_set), 32'd0);
    chk("r.pc",    32'(a_pc), 32'd3);

    // Empty program
    a_rst = 1;
    step();
    a_rst = 0;
    chk_a_reset("reset2");
    a_noi = 8'd0;
    s0 = a_set_cnt;
    v0 = a_valid_cnt;
    a_start = 1;
    step();
    a_start = 0;
    chk("empty.done", 32'(a_done), 32'd1);
    chk("empty.busy", 32'(a_busy), 32'd0);
    a_req = 1;
    repeat (3) step();
    a_req = 0;
    chk("empty.noset",   32'(a_set_cnt), 32'(s0));
    chk("empty.novalid", 32'(a_valid_cnt), 32'(v0));

    // Reset during EN_DATA
    a_rst = 1;
    step();
    a_rst = 0;
    a_noi = 8'd20;
    a_start = 1;
    step();
    a_start = 0;
    a_req = 1;
    step();
    a_req = 0;
    step();
    chk("midrst.en", 32'(a_en), 32'd1);
    v0 = a_valid_cnt;
    a_rst = 1;
    step();
    a_rst = 0;
    chk_a_reset("midrst");
    s0 = a_set_cnt;
    a_req = 1;
    repeat (3) step();
    a_req = 0;
    step();
    chk("midrst.novalid", 32'(a_valid_cnt), 32'(v0));
    chk("midrst.noset",   32'(a_set_cnt), 32'(s0));
    chk("midrst.idle",    32'(a_busy), 32'd0);

    // Auto-run to end of a 20-byte program
    b_noi = 8'd20;
    b_start = 1;
    step();
    b_start = 0;
    n = 0;
    while (!b_done && n < 200) begin
      step();
      n++;
    end
    chk("auto.timeout", 32'(b_done), 32'd1);
    chk("auto.count",   32'(b_bytes.size()), 32'd20);
    for (int i = 0; i < b_bytes.size() && i < 20; i++) chk("auto.byte", 32'(b_bytes[i]), 32'(mem[i]));
    for (int i = 1; i < b_times.size(); i++) chk("auto.spacing", 32'(b_times[i] - b_times[i-1]), 32'd4);
    chk("auto.last", 32'(b_byte), 32'h00);
    chk("auto.pc",   32'(b_pc), 32'd20);
    chk("auto.busy", 32'(b_busy), 32'd0);
    s0 = b_set_cnt;
    repeat (10) step();
    chk("auto.noset_after", 32'(b_set_cnt), 32'(s0));

    chk("a.strobe_shape", 32'(a_bad), 32'd0);
    chk("b.strobe_shape", 32'(b_bad), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rom_fetch_ctrl.md
Name: rom_fetch_ctrl

Overview:
- Read-side controller for the program ROMs of the 7-step processor.
- Drives the ROM's latch-then-enable protocol: set_addr, then en_data, with an 8-bit address. Captures each program byte and hands it to the CPU core on a request/valid handshake.
- Tracks the program counter, bounds fetches by the ROM's noi (number of instructions) output, and supports core-issued jumps.

Parameters:
- ADDR_W, 8, width of rom_addr, pc, jump_addr and noi.
- DATA_W, 8, width of rom_data and byte_out.
- AUTO_RUN, 0. When 1, bytes are fetched back-to-back with no fetch_req; when 0, each byte requires one fetch_req.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  begin program fetch from address 0; samples noi.
- fetch_req  in  1  core requests the next byte. Sampled only in WAIT.
- jump_en  in  1  load pc from jump_addr. Sampled only in WAIT.
- jump_addr  in  ADDR_W  jump target.
- noi  in  ADDR_W  program length in bytes, from the ROM.
- rom_data  in  DATA_W  ROM data output.
- rom_addr  out  ADDR_W  address presented to the ROM.
- rom_set_addr  out  1  ROM address latch strobe.
- rom_en_data  out  1  ROM data enable.
- byte_out  out  DATA_W  last captured byte; holds until the next capture.
- byte_valid  out  1  one-cycle pulse: byte_out is new.
- pc  out  ADDR_W  address of the next byte to fetch.
- busy  out  1  high in every state except IDLE and DONE.
- done  out  1  high while in DONE.

Behaviour:
- Clock and reset: one clock domain, clk. reset is synchronous, active-high, and wins over all other inputs.
- Reset values: all outputs 0, noi_q = 0, state = IDLE. Reset mid-fetch abandons the byte with no byte_valid pulse.
- States: IDLE, WAIT, SET_ADDR, EN_DATA, VALID, DONE.
- IDLE:
  - start=1: pc <= 0, noi_q <= noi, go to WAIT.
  - If noi = 0, go directly to DONE instead.
  - Other inputs are ignored.
- WAIT:
  - If pc >= noi_q, go to DONE. This check precedes the request check.
  - Otherwise, jump_en=1 sets pc <= jump_addr.
  - Otherwise, fetch_req=1 (or AUTO_RUN=1) goes to SET_ADDR.
  - jump_en and fetch_req in the same cycle: the jump wins. The request is dropped, and the fetch occurs on the next request from the new pc.
- SET_ADDR: rom_set_addr=1, rom_addr=pc, rom_en_data=0. Next state is EN_DATA.
- EN_DATA:
  - rom_set_addr=0, rom_en_data=1, rom_addr holds pc.
  - At the closing edge: byte_out <= rom_data, pc <= pc+1 (mod 2^ADDR_W), go to VALID.
- VALID: byte_valid=1 for exactly this cycle. Next state is WAIT.
- DONE:
  - done=1, pc holds.
  - start=1 restarts: pc <= 0, noi re-sampled, go to WAIT.
  - fetch_req and jump_en are ignored.
- Exclusivity: rom_set_addr and rom_en_data are never high in the same cycle. Each is exactly one cycle wide per fetch.
- Latency: fetch_req sampled in WAIT at edge t gives SET_ADDR in cycle t+1, EN_DATA in t+2, and byte_valid in t+3.
- Throughput:
  - AUTO_RUN=0: at most one byte per 4 cycles.
  - AUTO_RUN=1: one byte per 4 cycles continuously until pc = noi_q.
- Other ignored inputs: start while busy; fetch_req or jump_en outside WAIT.
- pc wrap: pc = 255 increments to 0. The done check uses noi_q, so with noi_q = 0 there is no wrap fetch.
- Out-of-range jump: jump_addr >= noi_q causes DONE on the next WAIT evaluation, with no ROM access.

Test Plan:
- Basic fetch:
  - Stimulus: reset; noi=20; start; fetch_req pulses.
  - Required: byte 0 = 0x20 and byte 1 = 0x00 (the fibonacci program), each byte_valid exactly 3 cycles after its fetch_req was sampled. pc = 2. Each strobe is one cycle wide; the two strobes never overlap.
- Run to end:
  - Stimulus: AUTO_RUN=1, noi=20.
  - Required: exactly 20 byte_valid pulses, bytes equal to ROM contents 0–19. Last byte 0x00; done rises and busy falls with pc = 20. No rom_set_addr after that.
- Jump:
  - Stimulus: in WAIT at pc=4, jump_en=1 with jump_addr=12 and fetch_req=1 in the same cycle.
  - Required: no fetch that cycle, pc = 12. The next fetch_req yields 0x8B.
  - Stimulus: jump_addr = 25.
  - Required: done with no ROM strobe.
- Empty program:
  - Stimulus: noi=0; start.
  - Required: DONE one cycle later, no strobes, byte_valid never high.
- Reset mid-operation:
  - Stimulus: assert reset during the EN_DATA cycle.
  - Required: next cycle all outputs 0, state IDLE, no byte_valid. fetch_req is then ignored until start.
- Restart and ignored inputs:
  - Stimulus: start while busy.
  - Required: no effect on pc.
  - Stimulus: start in DONE with noi=3.
  - Required: pc restarts at 0, exactly 3 bytes fetched (0x20, 0x00, 0x21), then done.
